// File: rtl/knn_point_bank.sv
// knn_point_bank: point store streaming LANES points per beat; `define KNN_BANK_PARITY_EN adds per-entry parity and o_parity_err.
module knn_point_bank #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int DEPTH = 128,
    parameter int LANES = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [X_W-1:0]       i_x,
    input  logic [Y_W-1:0]       i_y,
    input  logic                 i_rd_start,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [LANES*X_W-1:0] o_x,
    output logic [LANES*Y_W-1:0] o_y,
    output logic [LANES-1:0]     o_lane_mask,
    output logic                 o_last,
    output logic                 o_done,
    output logic [CW-1:0]        o_count,
    output logic                 o_busy
`ifdef KNN_BANK_PARITY_EN
    ,
    output logic                 o_parity_err,
    input  logic                 i_err_inject
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic [X_W-1:0] x_mem [DEPTH];
    logic [Y_W-1:0] y_mem [DEPTH];
    logic [CW-1:0] nxt, base, cnt_n, idx;
    logic wr_fire, byp;
    logic [LANES*X_W-1:0] x_n;
    logic [LANES*Y_W-1:0] y_n;
    logic [LANES-1:0] m_n;
    logic last_n;
`ifdef KNN_BANK_PARITY_EN
    logic par_mem [DEPTH];
    logic [LANES-1:0] par_q, p_n, mism;
    logic wr_par;
    assign wr_par = ^{i_x, i_y} ^ i_err_inject;
`endif
    assign o_wr_ready = rst && state == IDLE && o_count != CW'(DEPTH);
    assign wr_fire    = i_wr_valid && o_wr_ready && !i_clear;
    assign cnt_n      = o_count + CW'(wr_fire);
    assign base       = state == SCAN ? nxt : '0;
    assign last_n     = base + CW'(LANES) >= cnt_n;
    // The point written in the start cycle is not yet in memory, so forward it.
    always_comb begin
        x_n = '0;
        y_n = '0;
        m_n = '0;
        idx = '0;
        byp = 1'b0;
`ifdef KNN_BANK_PARITY_EN
        p_n = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            idx = base + CW'(k);
            byp = wr_fire && idx == o_count;
            if (idx < cnt_n) begin
                m_n[k] = 1'b1;
                x_n[k*X_W +: X_W] = byp ? i_x : x_mem[idx[CW-2:0]];
                y_n[k*Y_W +: Y_W] = byp ? i_y : y_mem[idx[CW-2:0]];
`ifdef KNN_BANK_PARITY_EN
                p_n[k] = byp ? wr_par : par_mem[idx[CW-2:0]];
`endif
            end
        end
    end
    always_ff @(posedge clk)
        if (wr_fire) begin
            x_mem[o_count[CW-2:0]] <= i_x;
            y_mem[o_count[CW-2:0]] <= i_y;
`ifdef KNN_BANK_PARITY_EN
            par_mem[o_count[CW-2:0]] <= wr_par;
`endif
        end
`ifdef KNN_BANK_PARITY_EN
    always_comb begin
        mism = '0;
        for (int k = 0; k < LANES; k++)
            mism[k] = ^{o_x[k*X_W +: X_W], o_y[k*Y_W +: Y_W], par_q[k]};
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            o_parity_err <= 1'b0;
            par_q        <= '0;
        end else begin
            o_parity_err <= !i_clear && (o_parity_err || (o_rd_valid && |(o_lane_mask & mism)));
            par_q        <= p_n;
        end
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            o_count     <= '0;
            nxt         <= '0;
            o_rd_valid  <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_lane_mask <= '0;
            o_last      <= 1'b0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
        end else if (i_clear) begin
            state       <= IDLE;
            o_count     <= '0;
            nxt         <= '0;
            o_rd_valid  <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_lane_mask <= '0;
            o_last      <= 1'b0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (wr_fire)
                o_count <= cnt_n;
            case (state)
                IDLE:
                    if (i_rd_start && cnt_n == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else if (i_rd_start) begin
                        state       <= SCAN;
                        o_busy      <= 1'b1;
                        o_rd_valid  <= 1'b1;
                        o_x         <= x_n;
                        o_y         <= y_n;
                        o_lane_mask <= m_n;
                        o_last      <= last_n;
                        nxt         <= CW'(LANES);
                    end
                SCAN:
                    if (i_rd_ready && o_last) begin
                        state       <= DONE;
                        o_done      <= 1'b1;
                        o_busy      <= 1'b0;
                        o_rd_valid  <= 1'b0;
                        o_last      <= 1'b0;
                        o_x         <= '0;
                        o_y         <= '0;
                        o_lane_mask <= '0;
                    end else if (i_rd_ready) begin
                        o_x         <= x_n;
                        o_y         <= y_n;
                        o_lane_mask <= m_n;
                        o_last      <= last_n;
                        nxt         <= nxt + CW'(LANES);
                    end
                default:
                    state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_knn_point_bank.sv
// tb_knn_point_bank: directed-vector bench for knn_point_bank at default parameters.
module tb_knn_point_bank;
    localparam int XW = 11, YW = 10, L = 4;
    logic clk = 1'b0, rst = 1'b0;
    logic i_clear = 0, i_wr_valid = 0, i_rd_start = 0, i_rd_ready = 0;
    logic [XW-1:0] i_x = '0;
    logic [YW-1:0] i_y = '0;
    logic o_wr_ready, o_rd_valid, o_last, o_done, o_busy;
    logic [L*XW-1:0] o_x, ex;
    logic [L*YW-1:0] o_y, ey;
    logic [L-1:0] o_lane_mask;
    logic [7:0] o_count;
    int nvec = 0, nerr = 0;
`ifdef KNN_BANK_PARITY_EN
    logic o_parity_err, i_err_inject = 0;
`endif
    knn_point_bank dut (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .i_x(i_x), .i_y(i_y), .i_rd_start(i_rd_start), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_x(o_x), .o_y(o_y), .o_lane_mask(o_lane_mask), .o_last(o_last), .o_done(o_done),
        .o_count(o_count), .o_busy(o_busy)
`ifdef KNN_BANK_PARITY_EN
        , .o_parity_err(o_parity_err), .i_err_inject(i_err_inject)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input int x, input int y);
        i_wr_valid = 1; i_x = XW'(x); i_y = YW'(y);
        tick();
        i_wr_valid = 0;
    endtask
    task automatic start();
        i_rd_start = 1;
        tick();
        i_rd_start = 0;
    endtask
    task automatic clear();
        i_clear = 1;
        tick();
        i_clear = 0;
    endtask
    task automatic test_reset();
        tick();
        nvec++;
        if (o_wr_ready !== 0 || o_rd_valid !== 0 || o_done !== 0 || o_busy !== 0 || o_count !== 0 || o_last !== 0 || o_lane_mask !== 0) begin
            nerr++;
            $display("FAIL reset_outputs: rdy=%b v=%b done=%b busy=%b cnt=%0d last=%b m=%b, want all 0", o_wr_ready, o_rd_valid, o_done, o_busy, o_count, o_last, o_lane_mask);
        end
        rst = 1;
        tick();
        nvec++;
        if (o_wr_ready !== 1) begin nerr++; $display("FAIL reset_ready: got %b want 1", o_wr_ready); end
    endtask
    task automatic test_full_scan();
        for (int i = 1; i <= 128; i++) wr(i, i);
        nvec++;
        if (o_count !== 128 || o_wr_ready !== 0) begin nerr++; $display("FAIL full_count: cnt=%0d rdy=%b want 128/0", o_count, o_wr_ready); end
        wr(999, 999);
        nvec++;
        if (o_count !== 128) begin nerr++; $display("FAIL full_saturate: cnt=%0d want 128", o_count); end
        i_rd_ready = 1;
        start();
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < L; j++) begin ex[j*XW +: XW] = XW'(4*k+j+1); ey[j*YW +: YW] = YW'(4*k+j+1); end
            nvec++;
            if (o_rd_valid !== 1 || o_busy !== 1 || o_x !== ex || o_y !== ey || o_lane_mask !== 4'hf || o_last !== (k == 31)) begin
                nerr++;
                $display("FAIL full_beat%0d: v=%b busy=%b x=%h y=%h m=%b last=%b want x=%h y=%h m=1111 last=%b", k, o_rd_valid, o_busy, o_x, o_y, o_lane_mask, o_last, ex, ey, k == 31);
            end
            tick();
        end
        nvec++;
        if (o_done !== 1 || o_rd_valid !== 0 || o_busy !== 0) begin nerr++; $display("FAIL full_done: done=%b v=%b busy=%b want 1/0/0", o_done, o_rd_valid, o_busy); end
        tick();
        nvec++;
        if (o_done !== 0 || o_count !== 128) begin nerr++; $display("FAIL full_done_pulse: done=%b cnt=%0d want 0/128", o_done, o_count); end
    endtask
    task automatic test_partial();
        clear();
        for (int i = 10; i <= 15; i++) wr(i, i);
        i_rd_ready = 1;
        start();
        nvec++;
        if (o_rd_valid !== 1 || o_x !== {11'd13, 11'd12, 11'd11, 11'd10} || o_y !== {10'd13, 10'd12, 10'd11, 10'd10} || o_lane_mask !== 4'b1111 || o_last !== 0) begin
            nerr++; $display("FAIL partial_beat0: v=%b x=%h y=%h m=%b last=%b", o_rd_valid, o_x, o_y, o_lane_mask, o_last);
        end
        tick();
        nvec++;
        if (o_rd_valid !== 1 || o_x !== {11'd0, 11'd0, 11'd15, 11'd14} || o_y !== {10'd0, 10'd0, 10'd15, 10'd14} || o_lane_mask !== 4'b0011 || o_last !== 1) begin
            nerr++; $display("FAIL partial_beat1: v=%b x=%h y=%h m=%b last=%b want m=0011 last=1", o_rd_valid, o_x, o_y, o_lane_mask, o_last);
        end
        tick();
        nvec++;
        if (o_done !== 1 || o_rd_valid !== 0) begin nerr++; $display("FAIL partial_done: done=%b v=%b want 1/0", o_done, o_rd_valid); end
        tick();
    endtask
    task automatic test_backpressure();
        clear();
        for (int i = 0; i < 40; i++) wr(i + 100, i + 200);
        i_rd_ready = 1;
        start();
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < L; j++) begin ex[j*XW +: XW] = XW'(4*k+j+100); ey[j*YW +: YW] = YW'(4*k+j+200); end
            if (k == 2) begin
                i_rd_ready = 0;
                for (int c = 0; c < 3; c++) begin
                    tick();
                    nvec++;
                    if (o_rd_valid !== 1 || o_x !== ex || o_y !== ey || o_lane_mask !== 4'hf) begin
                        nerr++; $display("FAIL bp_hold%0d: v=%b x=%h y=%h m=%b want x=%h y=%h", c, o_rd_valid, o_x, o_y, o_lane_mask, ex, ey);
                    end
                end
                i_rd_ready = 1;
            end
            nvec++;
            if (o_rd_valid !== 1 || o_x !== ex || o_y !== ey || o_lane_mask !== 4'hf || o_last !== (k == 9)) begin
                nerr++; $display("FAIL bp_beat%0d: v=%b x=%h y=%h last=%b want x=%h y=%h last=%b", k, o_rd_valid, o_x, o_y, o_last, ex, ey, k == 9);
            end
            tick();
        end
        nvec++;
        if (o_done !== 1) begin nerr++; $display("FAIL bp_done: got %b want 1", o_done); end
        tick();
    endtask
    task automatic test_start_edges();
        clear();
        start();
        nvec++;
        if (o_done !== 1 || o_rd_valid !== 0) begin nerr++; $display("FAIL empty_start: done=%b v=%b want 1/0", o_done, o_rd_valid); end
        tick();
        nvec++;
        if (o_done !== 0 || o_rd_valid !== 0 || o_busy !== 0) begin nerr++; $display("FAIL empty_after: done=%b v=%b busy=%b want 0", o_done, o_rd_valid, o_busy); end
        for (int i = 50; i < 53; i++) wr(i, i + 1);
        i_wr_valid = 1; i_x = 11'd53; i_y = 10'd54; i_rd_start = 1;
        tick();
        i_wr_valid = 0; i_rd_start = 0;
        nvec++;
        if (o_count !== 4 || o_rd_valid !== 1 || o_x !== {11'd53, 11'd52, 11'd51, 11'd50} || o_y !== {10'd54, 10'd53, 10'd52, 10'd51} || o_lane_mask !== 4'hf || o_last !== 1) begin
            nerr++; $display("FAIL start_with_write: cnt=%0d v=%b x=%h y=%h m=%b last=%b", o_count, o_rd_valid, o_x, o_y, o_lane_mask, o_last);
        end
        tick();
        nvec++;
        if (o_done !== 1) begin nerr++; $display("FAIL start_with_write_done: got %b want 1", o_done); end
        tick();
    endtask
    task automatic test_clear_mid_scan();
        clear();
        for (int i = 1; i <= 128; i++) wr(i, i);
        start();
        for (int k = 0; k < 5; k++) tick();
        nvec++;
        if (o_rd_valid !== 1 || o_x[XW-1:0] !== 11'd21) begin nerr++; $display("FAIL clear_beat5: v=%b lane0=%0d want 1/21", o_rd_valid, o_x[XW-1:0]); end
        i_clear = 1; i_wr_valid = 1; i_x = 11'd77; i_y = 10'd77;
        tick();
        i_clear = 0; i_wr_valid = 0;
        nvec++;
        if (o_rd_valid !== 0 || o_count !== 0 || o_done !== 0 || o_busy !== 0 || o_last !== 0) begin
            nerr++; $display("FAIL clear_abort: v=%b cnt=%0d done=%b busy=%b last=%b want 0", o_rd_valid, o_count, o_done, o_busy, o_last);
        end
        tick();
        nvec++;
        if (o_done !== 0) begin nerr++; $display("FAIL clear_no_done: got %b want 0", o_done); end
        wr(7, 8);
        wr(9, 10);
        nvec++;
        if (o_count !== 2) begin nerr++; $display("FAIL clear_rewrite_count: got %0d want 2", o_count); end
        start();
        nvec++;
        if (o_x !== {11'd0, 11'd0, 11'd9, 11'd7} || o_y !== {10'd0, 10'd0, 10'd10, 10'd8} || o_lane_mask !== 4'b0011 || o_last !== 1) begin
            nerr++; $display("FAIL clear_rewrite_scan: x=%h y=%h m=%b last=%b", o_x, o_y, o_lane_mask, o_last);
        end
        tick();
        tick();
    endtask
    task automatic test_reset_mid_scan();
        clear();
        for (int i = 0; i < 8; i++) wr(i + 1, i + 1);
        i_rd_ready = 0;
        start();
        nvec++;
        if (o_rd_valid !== 1 || o_busy !== 1) begin nerr++; $display("FAIL rstscan_pre: v=%b busy=%b want 1/1", o_rd_valid, o_busy); end
        #1 rst = 0;
        #1;
        nvec++;
        if (o_rd_valid !== 0 || o_busy !== 0 || o_count !== 0 || o_x !== 0 || o_y !== 0 || o_lane_mask !== 0 || o_wr_ready !== 0 || o_done !== 0) begin
            nerr++; $display("FAIL rstscan_async: v=%b busy=%b cnt=%0d x=%h m=%b rdy=%b want all 0", o_rd_valid, o_busy, o_count, o_x, o_lane_mask, o_wr_ready);
        end
        rst = 1;
        tick();
        i_rd_ready = 1;
    endtask
`ifdef KNN_BANK_PARITY_EN
    task automatic test_parity();
        clear();
        wr(1, 1);
        wr(2, 3);
        i_err_inject = 1;
        wr(5, 6);
        i_err_inject = 0;
        wr(7, 8);
        i_rd_ready = 0;
        start();
        nvec++;
        if (o_parity_err !== 0) begin nerr++; $display("FAIL parity_pre: got %b want 0", o_parity_err); end
        tick();
        nvec++;
        if (o_parity_err !== 1) begin nerr++; $display("FAIL parity_set: got %b want 1", o_parity_err); end
        i_rd_ready = 1;
        tick();
        tick();
        nvec++;
        if (o_parity_err !== 1) begin nerr++; $display("FAIL parity_sticky: got %b want 1", o_parity_err); end
        clear();
        nvec++;
        if (o_parity_err !== 0) begin nerr++; $display("FAIL parity_clear: got %b want 0", o_parity_err); end
    endtask
`endif
    initial begin
        test_reset();
        test_full_scan();
        test_partial();
        test_backpressure();
        test_start_edges();
        test_clear_mid_scan();
        test_reset_mid_scan();
`ifdef KNN_BANK_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
